// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - RV32 instruction-fetch stage with PC select, store-hazard fetch block and IF/ID register
//
// Purpose:
//   Holds the program counter and picks the next PC from PC+4, a branch/jal
//   target or a jalr target. Fetches that would read a word an in-flight
//   store is about to overwrite are blocked. The fetched instruction word and
//   its PC are captured in the IF/ID pipeline register.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   squash IF/ID payload, allow PC update without IMemReady_i
//   IF_ID_En_i                IF/ID load enable
//   PCEn_i                    PC update enable (stall when 0)
//   PCsrc_i[1:0]              0/3 = PC+4, 1 = pcPlusImm_i, 2 = regPlusImm_i
//   pcPlusImm_i[31:0]         branch/jal target
//   regPlusImm_i[31:0]        jalr target and early store address
//   IMemReady_i, IMemInstr_i  instruction memory handshake and data
//   ALUout_EX_i, MemWrite_EX_i, MemWrite_beforeID_i, DMemReady_i
//                             store tracking used by the fetch block
//   PCbeforeReg_o, validReq_o instruction memory address and request valid
//   rs1_o, rs2_o, rd_o, Instr31_7_o, op_o, funct3_o, funct7_5_o,
//   PC_o, pcPlus4_o, forbiddenRead_o, IMemReady_o
//                             IF/ID register outputs

module instr_fetch_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        IF_ID_En_i,
  input  logic        PCEn_i,
  input  logic [1:0]  PCsrc_i,
  input  logic [31:0] pcPlusImm_i,
  input  logic [31:0] regPlusImm_i,
  input  logic        IMemReady_i,
  input  logic [31:0] IMemInstr_i,
  input  logic [31:0] ALUout_EX_i,
  input  logic        MemWrite_EX_i,
  input  logic        MemWrite_beforeID_i,
  input  logic        DMemReady_i,
  output logic [31:0] PCbeforeReg_o,
  output logic        validReq_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [24:0] Instr31_7_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_5_o,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o,
  output logic        forbiddenRead_o,
  output logic        IMemReady_o
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [31:0] r_pc;
  logic [24:0] r_instr31_7;
  logic [6:0]  r_op;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc_plus4_id;
  logic        r_forbidden_id;
  logic        r_imem_ready_id;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_mux_pc;
  logic [31:0] w_next_pc;
  logic        w_store_done;
  logic        w_forbidden;
  logic        w_pc_en;

  assign w_pc_plus4 = r_pc + 32'd4;

  // The early store address hits the word being fetched; the block is lifted
  // only once the same store has reached EX and its memory write completed.
  assign w_store_done = (ALUout_EX_i == regPlusImm_i) && MemWrite_EX_i && DMemReady_i;
  assign w_forbidden  = (r_pc[31:2] == regPlusImm_i[31:2]) && MemWrite_beforeID_i && !w_store_done;

  always_comb begin
    w_mux_pc = w_pc_plus4;
    case (PCsrc_i)
      2'd1:    w_mux_pc = pcPlusImm_i;
      2'd2:    w_mux_pc = regPlusImm_i;
      default: w_mux_pc = w_pc_plus4;
    endcase
  end

  assign w_next_pc = w_forbidden ? r_pc : w_mux_pc;

  // A flush redirects the PC even while the instruction memory is not ready.
  assign w_pc_en = PCEn_i && (IMemReady_i || flush_i) && !w_forbidden;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (w_pc_en) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr31_7   <= '0;
      r_op          <= '0;
      r_pc_id       <= '0;
      r_pc_plus4_id <= '0;
    end else if (flush_i) begin
      r_instr31_7   <= '0;
      r_op          <= '0;
      r_pc_id       <= '0;
      r_pc_plus4_id <= '0;
    end else if (IF_ID_En_i) begin
      r_instr31_7   <= IMemInstr_i[31:7];
      r_op          <= IMemInstr_i[6:0];
      r_pc_id       <= r_pc;
      r_pc_plus4_id <= w_pc_plus4;
    end
  end

  // Status bits survive a flush so the next stage still sees why the slot
  // was empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_forbidden_id  <= 1'b0;
      r_imem_ready_id <= 1'b0;
    end else if (IF_ID_En_i) begin
      r_forbidden_id  <= w_forbidden;
      r_imem_ready_id <= IMemReady_i;
    end
  end

  assign PCbeforeReg_o   = r_pc;
  assign validReq_o      = !w_forbidden;
  assign Instr31_7_o     = r_instr31_7;
  assign op_o            = r_op;
  assign rd_o            = r_instr31_7[4:0];
  assign funct3_o        = r_instr31_7[7:5];
  assign rs1_o           = r_instr31_7[12:8];
  assign rs2_o           = r_instr31_7[17:13];
  assign funct7_5_o      = r_instr31_7[23];
  assign PC_o            = r_pc_id;
  assign pcPlus4_o       = r_pc_plus4_id;
  assign forbiddenRead_o = r_forbidden_id;
  assign IMemReady_o     = r_imem_ready_id;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage with a behavioural model
module tb_instr_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        IF_ID_En_i;
  logic        PCEn_i;
  logic [1:0]  PCsrc_i;
  logic [31:0] pcPlusImm_i;
  logic [31:0] regPlusImm_i;
  logic        IMemReady_i;
  logic [31:0] IMemInstr_i;
  logic [31:0] ALUout_EX_i;
  logic        MemWrite_EX_i;
  logic        MemWrite_beforeID_i;
  logic        DMemReady_i;
  logic [31:0] PCbeforeReg_o;
  logic        validReq_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [24:0] Instr31_7_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_5_o;
  logic [31:0] PC_o;
  logic [31:0] pcPlus4_o;
  logic        forbiddenRead_o;
  logic        IMemReady_o;

  instr_fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .IF_ID_En_i(IF_ID_En_i),
    .PCEn_i(PCEn_i), .PCsrc_i(PCsrc_i), .pcPlusImm_i(pcPlusImm_i),
    .regPlusImm_i(regPlusImm_i), .IMemReady_i(IMemReady_i), .IMemInstr_i(IMemInstr_i),
    .ALUout_EX_i(ALUout_EX_i), .MemWrite_EX_i(MemWrite_EX_i),
    .MemWrite_beforeID_i(MemWrite_beforeID_i), .DMemReady_i(DMemReady_i),
    .PCbeforeReg_o(PCbeforeReg_o), .validReq_o(validReq_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .Instr31_7_o(Instr31_7_o),
    .op_o(op_o), .funct3_o(funct3_o), .funct7_5_o(funct7_5_o),
    .PC_o(PC_o), .pcPlus4_o(pcPlus4_o), .forbiddenRead_o(forbiddenRead_o),
    .IMemReady_o(IMemReady_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Model state: the PC and the IF/ID contents kept as a whole word.
  bit          m_valid = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_id;
  logic [31:0] m_pc4_id;
  logic        m_fr_id;
  logic        m_imr_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_forbidden();
    logic same_word;
    logic store_done;
    same_word  = (m_pc >> 2) == (regPlusImm_i >> 2);
    store_done = (ALUout_EX_i == regPlusImm_i) && MemWrite_EX_i && DMemReady_i;
    return same_word && MemWrite_beforeID_i && !store_done;
  endfunction

  task automatic compare_all();
    if (!m_valid) return;
    chk("pc",       PCbeforeReg_o, m_pc);
    chk("validReq", {31'd0, validReq_o}, {31'd0, !m_forbidden()});
    chk("op",       {25'd0, op_o},  m_instr & 32'h7F);
    chk("rd",       {27'd0, rd_o},  (m_instr >> 7) & 32'h1F);
    chk("funct3",   {29'd0, funct3_o}, (m_instr >> 12) & 32'h7);
    chk("rs1",      {27'd0, rs1_o}, (m_instr >> 15) & 32'h1F);
    chk("rs2",      {27'd0, rs2_o}, (m_instr >> 20) & 32'h1F);
    chk("funct7_5", {31'd0, funct7_5_o}, (m_instr >> 30) & 32'h1);
    chk("instr31_7", {7'd0, Instr31_7_o}, m_instr >> 7);
    chk("PC_o",     PC_o, m_pc_id);
    chk("pcPlus4_o", pcPlus4_o, m_pc4_id);
    chk("forbiddenRead_o", {31'd0, forbiddenRead_o}, {31'd0, m_fr_id});
    chk("IMemReady_o", {31'd0, IMemReady_o}, {31'd0, m_imr_id});
  endtask

  task automatic model_next();
    logic        fr;
    logic [31:0] target;
    if (rst_i) begin
      m_valid  = 1;
      m_pc     = 32'hBFC00000;
      m_instr  = 0;
      m_pc_id  = 0;
      m_pc4_id = 0;
      m_fr_id  = 0;
      m_imr_id = 0;
      return;
    end
    if (!m_valid) return;
    fr = m_forbidden();
    if (IF_ID_En_i) begin
      m_fr_id  = fr;
      m_imr_id = IMemReady_i;
    end
    if (flush_i) begin
      m_instr = 0; m_pc_id = 0; m_pc4_id = 0;
    end else if (IF_ID_En_i) begin
      m_instr = IMemInstr_i; m_pc_id = m_pc; m_pc4_id = m_pc + 4;
    end
    if (PCsrc_i == 1)      target = pcPlusImm_i;
    else if (PCsrc_i == 2) target = regPlusImm_i;
    else                   target = m_pc + 4;
    if (PCEn_i && (IMemReady_i || flush_i) && !fr) m_pc = target;
  endtask

  // Inputs are set just after a rising edge; this compares at the falling
  // edge, advances the model, and returns just after the next rising edge.
  task automatic tick();
    @(negedge clk_i);
    compare_all();
    model_next();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1; flush_i = 0; IF_ID_En_i = 0; PCEn_i = 1; PCsrc_i = 0;
    pcPlusImm_i = 0; regPlusImm_i = 0; IMemReady_i = 1; IMemInstr_i = 0;
    ALUout_EX_i = 0; MemWrite_EX_i = 0; MemWrite_beforeID_i = 0; DMemReady_i = 0;
    @(posedge clk_i); #1;
    tick();
    chk("reset pc", PCbeforeReg_o, 32'hBFC00000);
    chk("reset PC_o", PC_o, 32'h0);
    chk("reset op", {25'd0, op_o}, 32'h0);

    rst_i = 0;
    tick(); chk("seq pc+4", PCbeforeReg_o, 32'hBFC00004);
    tick(); chk("seq pc+8", PCbeforeReg_o, 32'hBFC00008);

    PCsrc_i = 1; pcPlusImm_i = 32'h100;
    tick(); chk("branch target", PCbeforeReg_o, 32'h100);
    PCsrc_i = 2; regPlusImm_i = 32'h204;
    tick(); chk("jalr target", PCbeforeReg_o, 32'h204);
    PCsrc_i = 3;
    tick(); chk("sel3 pc+4", PCbeforeReg_o, 32'h208);

    PCsrc_i = 1; pcPlusImm_i = 32'h200;
    tick(); chk("goto 0x200", PCbeforeReg_o, 32'h200);
    PCsrc_i = 0; regPlusImm_i = 32'h202; MemWrite_beforeID_i = 1; MemWrite_EX_i = 0;
    #1 chk("blocked validReq", {31'd0, validReq_o}, 32'd0);
    tick(); chk("blocked pc holds", PCbeforeReg_o, 32'h200);
    ALUout_EX_i = 32'h202; MemWrite_EX_i = 1; DMemReady_i = 1;
    #1 chk("unblocked validReq", {31'd0, validReq_o}, 32'd1);
    tick(); chk("unblocked pc", PCbeforeReg_o, 32'h204);
    MemWrite_beforeID_i = 0; MemWrite_EX_i = 0; DMemReady_i = 0;

    IMemInstr_i = 32'h00A28293; IF_ID_En_i = 1;
    tick();
    chk("addi op", {25'd0, op_o}, 32'h13);
    chk("addi rd", {27'd0, rd_o}, 32'd5);
    chk("addi funct3", {29'd0, funct3_o}, 32'd0);
    chk("addi rs1", {27'd0, rs1_o}, 32'd5);
    chk("addi rs2", {27'd0, rs2_o}, 32'd10);
    chk("addi funct7_5", {31'd0, funct7_5_o}, 32'd0);
    chk("addi PC_o", PC_o, 32'h204);
    chk("addi pcPlus4_o", pcPlus4_o, 32'h208);

    flush_i = 1; IMemReady_i = 0; PCsrc_i = 1; pcPlusImm_i = 32'h300;
    tick();
    chk("flush pc", PCbeforeReg_o, 32'h300);
    chk("flush op", {25'd0, op_o}, 32'h0);
    chk("flush PC_o", PC_o, 32'h0);
    chk("flush IMemReady_o", {31'd0, IMemReady_o}, 32'h0);

    flush_i = 0; IMemReady_i = 1; PCEn_i = 0; PCsrc_i = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("stall pc", PCbeforeReg_o, 32'h300);
    chk("stall PC_o", PC_o, 32'h300);
    rst_i = 1;
    tick();
    chk("stall reset pc", PCbeforeReg_o, 32'hBFC00000);
    chk("stall reset op", {25'd0, op_o}, 32'h0);
    chk("stall reset PC_o", PC_o, 32'h0);
    chk("stall reset IMemReady_o", {31'd0, IMemReady_o}, 32'h0);
    rst_i = 0; PCEn_i = 1;

    for (int n = 0; n < 3000; n++) begin
      rst_i       = ($urandom % 64) == 0;
      flush_i     = ($urandom % 8) == 0;
      IF_ID_En_i  = ($urandom % 4) != 0;
      PCEn_i      = ($urandom % 8) != 0;
      IMemReady_i = ($urandom % 4) != 0;
      PCsrc_i     = 2'($urandom % 4);
      pcPlusImm_i = $urandom;
      if ($urandom % 2) regPlusImm_i = {m_pc[31:2], 2'($urandom % 4)};
      else              regPlusImm_i = $urandom;
      ALUout_EX_i = ($urandom % 2) ? regPlusImm_i : $urandom;
      MemWrite_EX_i       = 1'($urandom % 2);
      MemWrite_beforeID_i = 1'($urandom % 2);
      DMemReady_i         = 1'($urandom % 2);
      IMemInstr_i         = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
